// File: rtl/skintone_classifier_pipe.sv
// Multi-lane skin-tone scorer: rotated-ellipse distance in Cb/Cr space through a stall-together pipeline,
// with shadow/active coefficient banks that swap only once the pipeline has drained.
module skintone_classifier_pipe #(
  parameter int LANES    = 1,
  parameter int FP_WIDTH = 32,
  parameter int FP_FRAC  = 16,
  parameter int CNT_W    = 24
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [24*LANES-1:0]  pixel_datain,
  input  logic                 pixel_datain_valid,
  input  logic                 pixel_datain_last,
  output logic                 pixel_datain_ready,
  output logic [8*LANES-1:0]   result_dataout,
  output logic                 result_dataout_valid,
  output logic                 result_dataout_last,
  input  logic                 result_dataout_ready,
  input  logic                 mode,
  input  logic                 cfg_we,
  input  logic [3:0]           cfg_addr,
  input  logic [FP_WIDTH-1:0]  cfg_wdata,
  input  logic                 cfg_commit,
  output logic                 cfg_busy,
  output logic [CNT_W-1:0]     frame_count,
  output logic                 frame_count_valid,
  output logic [1:0]           cfg_state
);
  localparam int W     = FP_WIDTH;
  localparam int F     = FP_FRAC;
  localparam int NREG  = 11;
  localparam int NRANK = 10;

  localparam logic [1:0] ST_RUN   = 2'd0;
  localparam logic [1:0] ST_DRAIN = 2'd1;
  localparam logic [1:0] ST_SWAP  = 2'd2;

  typedef logic signed [W-1:0] fp_t;
  localparam logic signed [W-F-1:0] IP_MAX = 255;

  // Full-width signed product, fraction realigned by dropping the low F bits (floor).
  function automatic fp_t fmul(input fp_t a, input fp_t b);
    logic [2*W-1:0] p;
    p = {{W{a[W-1]}}, a} * {{W{b[W-1]}}, b};
    return fp_t'(p[W+F-1:F]);
  endfunction

  // Handshake contract: a beat moves on either side only in a cycle where valid and ready are
  // both high at the rising edge; a producer holding valid keeps its data and last stable until then.

  logic [1:0]   state_q, state_d;
  logic [W-1:0] shadow_q [NREG];
  logic [W-1:0] shadow_d [NREG];
  logic [W-1:0] active_q [NREG];
  logic [W-1:0] active_d [NREG];

  fp_t c_cx, c_cy, c_cos, c_sin, c_ecx, c_ecy, c_a2, c_b2, c_rad, c_fac, neg_sin;
  logic [7:0] c_thr;

  assign c_cx    = active_q[0];
  assign c_cy    = active_q[1];
  assign c_cos   = active_q[2];
  assign c_sin   = active_q[3];
  assign c_ecx   = active_q[4];
  assign c_ecy   = active_q[5];
  assign c_a2    = active_q[6];
  assign c_b2    = active_q[7];
  assign c_rad   = active_q[8];
  assign c_fac   = active_q[9];
  assign c_thr   = active_q[10][7:0];
  assign neg_sin = -c_sin;

  // Rank 0 holds the accepted beat, rank 9 is the output register.
  logic [NRANK-1:0] v_q, v_d, last_q, last_d, mode_q, mode_d;
  logic advance, accept, out_hs;

  logic [15:0] pix_q [LANES];
  logic [15:0] pix_d [LANES];
  fp_t cb_q [LANES], cb_d [LANES], cr_q [LANES], cr_d [LANES];
  fp_t pcb_q [LANES], pcb_d [LANES], psr_q [LANES], psr_d [LANES];
  fp_t pnsc_q [LANES], pnsc_d [LANES], pccr_q [LANES], pccr_d [LANES];
  fp_t x_q [LANES], x_d [LANES], y_q [LANES], y_d [LANES];
  fp_t xx_q [LANES], xx_d [LANES], yy_q [LANES], yy_d [LANES];
  fp_t ax_q [LANES], ax_d [LANES], by_q [LANES], by_d [LANES];
  fp_t dist_q [LANES], dist_d [LANES], diff_q [LANES], diff_d [LANES];
  fp_t score_q [LANES], score_d [LANES];
  logic [LANES-1:0]   inside_q, inside_d, skin_q, skin_d;
  logic [8*LANES-1:0] res_q, res_d;

  logic [CNT_W-1:0] acc_q, acc_d, fc_q, fc_d, inc;
  logic             fcv_q, fcv_d;

  assign advance              = !v_q[NRANK-1] || result_dataout_ready;
  assign pixel_datain_ready   = advance && (state_q == ST_RUN);
  assign accept               = pixel_datain_valid && pixel_datain_ready;
  assign out_hs               = v_q[NRANK-1] && result_dataout_ready;
  assign result_dataout       = res_q;
  assign result_dataout_valid = v_q[NRANK-1];
  assign result_dataout_last  = last_q[NRANK-1];
  assign cfg_busy             = (state_q != ST_RUN);
  assign cfg_state            = state_q;
  assign frame_count          = fc_q;
  assign frame_count_valid    = fcv_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:   if (cfg_commit) state_d = ST_DRAIN;
      ST_DRAIN: if (!(|v_q)) state_d = ST_SWAP;
      ST_SWAP:  state_d = ST_RUN;
      default:  state_d = ST_RUN;
    endcase
  end

  always_comb begin
    shadow_d = shadow_q;
    active_d = active_q;
    if (cfg_we && (cfg_addr < 4'(NREG))) shadow_d[cfg_addr] = cfg_wdata;
    if (state_q == ST_SWAP) active_d = shadow_q;
  end

  always_comb begin
    v_d    = v_q;
    last_d = last_q;
    mode_d = mode_q;
    if (advance) begin
      v_d    = {v_q[NRANK-2:0], accept};
      last_d = {last_q[NRANK-2:0], pixel_datain_last};
      mode_d = {mode_q[NRANK-2:0], mode};
    end
  end

  logic signed [W-F-1:0] ip;
  logic [7:0]            sat;

  always_comb begin
    pix_d    = pix_q;
    cb_d     = cb_q;
    cr_d     = cr_q;
    pcb_d    = pcb_q;
    psr_d    = psr_q;
    pnsc_d   = pnsc_q;
    pccr_d   = pccr_q;
    x_d      = x_q;
    y_d      = y_q;
    xx_d     = xx_q;
    yy_d     = yy_q;
    ax_d     = ax_q;
    by_d     = by_q;
    dist_d   = dist_q;
    diff_d   = diff_q;
    inside_d = inside_q;
    score_d  = score_q;
    skin_d   = skin_q;
    res_d    = res_q;
    ip       = '0;
    sat      = '0;
    if (advance) begin
      for (int k = 0; k < LANES; k++) begin
        pix_d[k]    = pixel_datain[24*k +: 16];
        cb_d[k]     = fp_t'({{(W-8){1'b0}}, pix_q[k][7:0]} << F) - c_cx;
        cr_d[k]     = fp_t'({{(W-8){1'b0}}, pix_q[k][15:8]} << F) - c_cy;
        pcb_d[k]    = fmul(c_cos, cb_q[k]);
        psr_d[k]    = fmul(c_sin, cr_q[k]);
        pnsc_d[k]   = fmul(neg_sin, cb_q[k]);
        pccr_d[k]   = fmul(c_cos, cr_q[k]);
        x_d[k]      = pcb_q[k] + psr_q[k] - c_ecx;
        y_d[k]      = pnsc_q[k] + pccr_q[k] - c_ecy;
        xx_d[k]     = fmul(x_q[k], x_q[k]);
        yy_d[k]     = fmul(y_q[k], y_q[k]);
        ax_d[k]     = fmul(c_a2, xx_q[k]);
        by_d[k]     = fmul(c_b2, yy_q[k]);
        dist_d[k]   = ax_q[k] + by_q[k];
        inside_d[k] = (dist_q[k] <= c_rad);
        diff_d[k]   = c_rad - dist_q[k];
        score_d[k]  = inside_q[k] ? fmul(c_fac, diff_q[k]) : '0;
        // Integer part of the score clamped to a byte; skin uses the clamped value in both modes.
        ip = score_q[k][W-1:F];
        if (ip[W-F-1])     sat = 8'h00;
        else if (ip > IP_MAX) sat = 8'hFF;
        else               sat = ip[7:0];
        skin_d[k]        = (sat > c_thr);
        res_d[8*k +: 8]  = mode_q[NRANK-2] ? {8{sat > c_thr}} : sat;
      end
    end
  end

  always_comb begin
    inc = '0;
    for (int k = 0; k < LANES; k++) inc = inc + CNT_W'(skin_q[k]);
    acc_d = acc_q;
    fc_d  = fc_q;
    fcv_d = 1'b0;
    if (out_hs) begin
      if (last_q[NRANK-1]) begin
        fc_d  = acc_q + inc;
        acc_d = '0;
        fcv_d = 1'b1;
      end else begin
        acc_d = acc_q + inc;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_RUN;
      for (int r = 0; r < NREG; r++) begin
        shadow_q[r] <= '0;
        active_q[r] <= '0;
      end
      v_q      <= '0;
      last_q   <= '0;
      mode_q   <= '0;
      for (int k = 0; k < LANES; k++) begin
        pix_q[k]   <= '0;
        cb_q[k]    <= '0;
        cr_q[k]    <= '0;
        pcb_q[k]   <= '0;
        psr_q[k]   <= '0;
        pnsc_q[k]  <= '0;
        pccr_q[k]  <= '0;
        x_q[k]     <= '0;
        y_q[k]     <= '0;
        xx_q[k]    <= '0;
        yy_q[k]    <= '0;
        ax_q[k]    <= '0;
        by_q[k]    <= '0;
        dist_q[k]  <= '0;
        diff_q[k]  <= '0;
        score_q[k] <= '0;
      end
      inside_q <= '0;
      skin_q   <= '0;
      res_q    <= '0;
      acc_q    <= '0;
      fc_q     <= '0;
      fcv_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      shadow_q <= shadow_d;
      active_q <= active_d;
      v_q      <= v_d;
      last_q   <= last_d;
      mode_q   <= mode_d;
      pix_q    <= pix_d;
      cb_q     <= cb_d;
      cr_q     <= cr_d;
      pcb_q    <= pcb_d;
      psr_q    <= psr_d;
      pnsc_q   <= pnsc_d;
      pccr_q   <= pccr_d;
      x_q      <= x_d;
      y_q      <= y_d;
      xx_q     <= xx_d;
      yy_q     <= yy_d;
      ax_q     <= ax_d;
      by_q     <= by_d;
      dist_q   <= dist_d;
      diff_q   <= diff_d;
      score_q  <= score_d;
      inside_q <= inside_d;
      skin_q   <= skin_d;
      res_q    <= res_d;
      acc_q    <= acc_d;
      fc_q     <= fc_d;
      fcv_q    <= fcv_d;
    end
  end

endmodule
